instr_decode_stage: RTL

Registered RV64-style instruction decode stage with a valid/ready handshake on both sides. It extracts the fixed instruction fields, classifies the encoding format, and generates the sign-extended immediate for that format. It flags unsupported encodings. It sits between the fetch stage and the register-file/ALU control logic, and its optional skid buffer sustains one instruction per cycle under back-pressure.

---
 rtl/rv_decode_pkg.sv | 44 ++++
 rtl/imm_gen.sv | 58 +++++
 rtl/instr_decode_stage.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rv_decode_pkg.sv
// Shared opcode constants, format codes and the decoded-instruction bundle
// used by the decode stage and its immediate generator.
package rv_decode_pkg;

   // Stored bundles are sized for the widest build; narrower builds use the low bits.
   localparam int XLEN_MAX = 64;

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_REG32  = 7'b0111011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_BAD = 3'd7
   } fmt_e;

   typedef struct packed {
      logic [6:0]          opcode;
      logic [4:0]          rd;
      logic [2:0]          funct3;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [6:0]          funct7;
      logic [XLEN_MAX-1:0] imm;
      fmt_e                fmt;
      logic                illegal;
      logic [XLEN_MAX-1:0] pc;
   } decoded_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational format classifier and sign-extended immediate generator.
module imm_gen
   import rv_decode_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]     instr,
   output fmt_e            fmt,
   output logic            illegal,
   output logic [XLEN-1:0] imm
);

   logic [31:0] imm32;

   // Every immediate fits in 32 bits sign-extended from instr[31], so widen once at the end.
   always_comb begin
      fmt     = FMT_BAD;
      illegal = 1'b1;
      imm32   = '0;
      if (instr[1:0] == 2'b11) begin
         case (instr[6:0])
            OP_REG, OP_REG32: begin
               fmt     = FMT_R;
               illegal = 1'b0;
            end
            OP_IMM, OP_IMM32, OP_LOAD, OP_JALR, OP_SYSTEM: begin
               fmt     = FMT_I;
               illegal = 1'b0;
               imm32   = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
               fmt     = FMT_S;
               illegal = 1'b0;
               imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
               fmt     = FMT_B;
               illegal = 1'b0;
               imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
               fmt     = FMT_U;
               illegal = 1'b0;
               imm32   = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
               fmt     = FMT_J;
               illegal = 1'b0;
               imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: ;
         endcase
      end
   end

   assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/instr_decode_stage.sv
// Registered instruction decode stage with valid/ready on both sides and an
// optional two-entry skid buffer for full throughput under back-pressure.
module instr_decode_stage
   import rv_decode_pkg::*;
#(
   parameter int XLEN = 64,
   parameter bit SKID = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [6:0]      out_opcode,
   output logic [4:0]      out_rd,
   output logic [2:0]      out_funct3,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [6:0]      out_funct7,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_illegal,
   output logic [XLEN-1:0] out_pc
);

   fmt_e            gen_fmt;
   logic            gen_illegal;
   logic [XLEN-1:0] gen_imm;
   decoded_t        in_dec;
   decoded_t        main_reg;
   logic            main_valid_reg;
   logic            in_ready_int;
   logic            in_xfer;
   logic            out_xfer;

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr   (in_instr),
      .fmt     (gen_fmt),
      .illegal (gen_illegal),
      .imm     (gen_imm)
   );

   always_comb begin
      in_dec         = '0;
      in_dec.opcode  = in_instr[6:0];
      in_dec.rd      = in_instr[11:7];
      in_dec.funct3  = in_instr[14:12];
      in_dec.rs1     = in_instr[19:15];
      in_dec.rs2     = in_instr[24:20];
      in_dec.funct7  = in_instr[31:25];
      in_dec.imm     = XLEN_MAX'($signed(gen_imm));
      in_dec.fmt     = gen_fmt;
      in_dec.illegal = gen_illegal;
      in_dec.pc      = XLEN_MAX'(in_pc);
   end

   // No transfer may be reported while reset is held, even before the first reset edge.
   assign out_valid = main_valid_reg & ~reset;
   assign in_ready  = in_ready_int;
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;

   generate
      if (SKID) begin : g_skid
         decoded_t skid_reg;
         logic     skid_valid_reg;
         logic     in_ready_reg;

         always_ff @(posedge clk) begin
            if (reset) begin
               main_reg       <= '0;
               main_valid_reg <= 1'b0;
               skid_reg       <= '0;
               skid_valid_reg <= 1'b0;
               in_ready_reg   <= 1'b1;
            end else if (!main_valid_reg || out_xfer) begin
               if (skid_valid_reg) begin
                  main_reg       <= skid_reg;
                  main_valid_reg <= 1'b1;
                  skid_valid_reg <= in_xfer;
                  in_ready_reg   <= ~in_xfer;
                  if (in_xfer) skid_reg <= in_dec;
               end else begin
                  main_valid_reg <= in_xfer;
                  in_ready_reg   <= 1'b1;
                  if (in_xfer) main_reg <= in_dec;
               end
            end else if (in_xfer) begin
               skid_reg       <= in_dec;
               skid_valid_reg <= 1'b1;
               in_ready_reg   <= 1'b0;
            end
         end

         // in_ready_reg mirrors ~skid_valid; reset only masks it, keeping out_ready off this path.
         assign in_ready_int = in_ready_reg & ~reset;
      end else begin : g_noskid
         always_ff @(posedge clk) begin
            if (reset) begin
               main_reg       <= '0;
               main_valid_reg <= 1'b0;
            end else if (in_xfer) begin
               main_reg       <= in_dec;
               main_valid_reg <= 1'b1;
            end else if (out_xfer) begin
               main_valid_reg <= 1'b0;
            end
         end

         assign in_ready_int = ~out_valid | out_ready;
      end
   endgenerate

   assign out_opcode  = main_reg.opcode;
   assign out_rd      = main_reg.rd;
   assign out_funct3  = main_reg.funct3;
   assign out_rs1     = main_reg.rs1;
   assign out_rs2     = main_reg.rs2;
   assign out_funct7  = main_reg.funct7;
   assign out_imm     = main_reg.imm[XLEN-1:0];
   assign out_fmt     = main_reg.fmt;
   assign out_illegal = main_reg.illegal;
   assign out_pc      = main_reg.pc[XLEN-1:0];

endmodule
